ysyx_23060077_wb_stage: RTL
===========================

# ysyx_23060077_wb_stage

Parametrised writeback stage for the ysyx_23060077 core, placed between the EXU/LSU/CSR results and the register file and retire/trace port. It buffers up to two completed instructions in a 2-entry FIFO, which decouples the stage from retire back-pressure. Its features:
- selects the result source per instruction and extracts/sign-extends load data by size and address offset;
- drives the register-file write port on retire;
- provides a combinational forwarding lookup over buffered entries.

## Interface
Parameters:
- DATA_WIDTH, 32, datapath width (32 or 64)
- RF_ADDR_W, 5, register index width (4 for RV32E)
- PC_WIDTH, 32, PC width

Ports (one clock; reset is synchronous and active-low):
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  synchronous active-low reset
- in_valid  in  1  completed instruction offered
- in_ready  out  1  stage can accept (registered, no path from retire_ready)
- in_sel  in  2  source: 0 EXU, 1 LSU load, 2 CSR, 3 reserved (treated as EXU)
- in_ld_size  in  2  0 byte, 1 half, 2 word, 3 double (64-bit only)
- in_ld_unsigned  in  1  zero-extend load
- in_addr_lo  in  log2(DATA_WIDTH/8)  load address low bits
- in_exu_result / in_lsu_rdata / in_csr_result  in  DATA_WIDTH  source data; in_lsu_rdata is the raw aligned bus word
- in_rd  in  RF_ADDR_W  destination
- in_rd_wen  in  1  instruction writes rd
- in_pc  in  PC_WIDTH  instruction PC
- retire_valid  out  1  head entry present
- retire_ready  in  1  retire consumer accepts
- retire_pc  out  PC_WIDTH  head PC
- rf_wen  out  1  = retire_valid & retire_ready & head.wen & head.rd!=0
- rf_waddr  out  RF_ADDR_W  head rd
- rf_wdata  out  DATA_WIDTH  head result
- lk_rs  in  RF_ADDR_W  forwarding lookup index
- lk_hit  out  1  a buffered entry writes lk_rs
- lk_data  out  DATA_WIDTH  data of youngest matching entry

## Operation
- Enqueue on in_valid & in_ready. The final result is computed at enqueue and stored:
  - EXU: in_exu_result.
  - CSR: in_csr_result.
  - LSU: lane = in_lsu_rdata shifted right by 8·(in_addr_lo aligned down to size), truncated to 8<<size bits, then sign- or zero-extended.
  - Address bits below the size alignment are ignored.
  - Size 3 on 32-bit is treated as word.
- Entry fields: result, rd, wen, pc.
- Entries with rd=0 are stored with wen forced to 0.
- Dequeue on retire_valid & retire_ready. rf_* is driven combinationally from the head entry in the same cycle.
- FIFO: 2 entries, 1-bit rd/wr pointers, 2-bit count.
  - in_ready = (count < 2).
  - retire_valid = (count != 0).
- Lookup:
  - lk_hit = 1 if any valid entry has wen & rd==lk_rs.
  - When both entries match, lk_data is taken from the younger (tail-side) entry.
  - lk_rs=0 always misses.
  - Returns lk_data=0 on miss.
- No flush input: every accepted instruction is committed.

## Timing
- Reset (rst_n low at an edge): count=0, pointers=0. Then retire_valid=0, rf_wen=0, lk_hit=0, and in_ready=1 from the first cycle after reset.
- Reset mid-operation discards buffered entries; no rf write occurs in the reset cycle.
- Latency: an instruction accepted at edge N is visible on retire_valid/rf_* in cycle N+1. The earliest rf write is at edge N+1.
- Throughput: 1 instr/cycle while retire_ready=1.
- Full (count=2):
  - in_ready=0, even if a dequeue happens in the same cycle.
  - In_ready rises the cycle after a dequeue.
- Enqueue and dequeue in the same cycle at count=1: count stays 1, and the head advances to the new entry.
- Empty: rf_wen=0 regardless of retire_ready.
- Lookup is purely combinational, reflects state after the last edge, and excludes the entry being enqueued this cycle.

## Structure
- Shared define file holds:
  - WB_SEL_EXU/LSU/CSR encodings
  - LD_SIZE_B/H/W/D encodings
  - the FIFO depth constant (2)
- Sub-module ysyx_23060077_ld_align: purely combinational load lane extract and extend, parametrised on DATA_WIDTH.
- FIFO and lookup stay in the top module.

## Test plan
- EXU write: in_sel=0, rd=5, exu=0x1234, retire_ready=1 → next cycle rf_wen=1, waddr=5, wdata=0x1234.
- Loads:
  - rdata=0x80FF7F01, signed byte, addr_lo=3 → wdata=0xFFFFFF80.
  - Unsigned half, addr_lo=2 → 0x000080FF.
  - Signed half, addr_lo=1 → lane uses offset 0 → 0x00007F01.
- Back-pressure:
  - retire_ready=0 while issuing 3 instrs → after 2 accepts in_ready=0 and the third is held.
  - Raise retire_ready → retire order preserved by PC, and in_ready returns 1 the cycle after the first dequeue.
- Forwarding:
  - Buffer rd=7 (0xA) then rd=7 (0xB), retire_ready=0, lk_rs=7 → lk_hit=1, lk_data=0xB.
  - lk_rs=0 → lk_hit=0.
- rd=0 with wen=1, exu=0xDEAD → retire_valid=1 but rf_wen=0, and no lookup hit.
- Assert rst_n=0 with 2 entries buffered → next cycle retire_valid=0, in_ready=1, no rf write during reset.

Source files
------------

// File: rtl/ysyx_23060077_wb_stage_pkg.sv
// Shared encodings for the ysyx_23060077 writeback stage: result source select,
// load size codes and the depth of the writeback buffer.
package ysyx_23060077_wb_stage_pkg;

    localparam logic [1:0] WB_SEL_EXU = 2'd0;
    localparam logic [1:0] WB_SEL_LSU = 2'd1;
    localparam logic [1:0] WB_SEL_CSR = 2'd2;

    localparam logic [1:0] LD_SIZE_B = 2'd0;
    localparam logic [1:0] LD_SIZE_H = 2'd1;
    localparam logic [1:0] LD_SIZE_W = 2'd2;
    localparam logic [1:0] LD_SIZE_D = 2'd3;

    localparam int WB_FIFO_DEPTH = 2;

endpackage

// File: rtl/ysyx_23060077_wb_stage_ld_align.sv
// Load lane extraction: picks the addressed byte/half/word/double out of the
// raw aligned bus word and sign- or zero-extends it to the datapath width.
module ysyx_23060077_ld_align
    import ysyx_23060077_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    localparam int AW = $clog2(DATA_WIDTH / 8)
) (
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [AW-1:0]         addr_lo,
    output logic [DATA_WIDTH-1:0] data
);

    logic [1:0]            eff_size;
    logic [AW-1:0]         low_mask;
    logic [AW-1:0]         offset;
    logic [DATA_WIDTH-1:0] lane;

    // Offset bits below the access size are dropped so misaligned addresses
    // read the naturally aligned lane that contains them.
    always_comb begin
        eff_size = size;
        if (DATA_WIDTH == 32 && size == LD_SIZE_D) begin
            eff_size = LD_SIZE_W;
        end
        case (eff_size)
            LD_SIZE_B: low_mask = '0;
            LD_SIZE_H: low_mask = AW'(1);
            LD_SIZE_W: low_mask = AW'(3);
            default:   low_mask = AW'(7);
        endcase
        offset = addr_lo & ~low_mask;
        lane   = rdata >> {offset, 3'b000};
        case (eff_size)
            LD_SIZE_B: begin
                if (is_unsigned) data = DATA_WIDTH'(lane[7:0]);
                else             data = DATA_WIDTH'($signed(lane[7:0]));
            end
            LD_SIZE_H: begin
                if (is_unsigned) data = DATA_WIDTH'(lane[15:0]);
                else             data = DATA_WIDTH'($signed(lane[15:0]));
            end
            LD_SIZE_W: begin
                if (is_unsigned) data = DATA_WIDTH'(lane[31:0]);
                else             data = DATA_WIDTH'($signed(lane[31:0]));
            end
            default:   data = lane;
        endcase
    end

endmodule

// File: rtl/ysyx_23060077_wb_stage.sv
// Writeback stage: 2-entry buffer of completed instructions feeding the register
// file write port, with a combinational forwarding lookup over buffered entries.
module ysyx_23060077_wb_stage
    import ysyx_23060077_wb_stage_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int RF_ADDR_W  = 5,
    parameter int PC_WIDTH   = 32
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [1:0]                      in_sel,
    input  logic [1:0]                      in_ld_size,
    input  logic                            in_ld_unsigned,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] in_addr_lo,
    input  logic [DATA_WIDTH-1:0]           in_exu_result,
    input  logic [DATA_WIDTH-1:0]           in_lsu_rdata,
    input  logic [DATA_WIDTH-1:0]           in_csr_result,
    input  logic [RF_ADDR_W-1:0]            in_rd,
    input  logic                            in_rd_wen,
    input  logic [PC_WIDTH-1:0]             in_pc,
    output logic                            retire_valid,
    input  logic                            retire_ready,
    output logic [PC_WIDTH-1:0]             retire_pc,
    output logic                            rf_wen,
    output logic [RF_ADDR_W-1:0]            rf_waddr,
    output logic [DATA_WIDTH-1:0]           rf_wdata,
    input  logic [RF_ADDR_W-1:0]            lk_rs,
    output logic                            lk_hit,
    output logic [DATA_WIDTH-1:0]           lk_data
);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic [RF_ADDR_W-1:0]  rd;
        logic                  wen;
        logic [PC_WIDTH-1:0]   pc;
    } entry_t;

    entry_t     mem [WB_FIFO_DEPTH];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;

    logic [DATA_WIDTH-1:0] ld_data;
    logic [DATA_WIDTH-1:0] new_result;
    logic                  enq;
    logic                  deq;
    entry_t                head;
    entry_t                second;
    logic                  head_hit;
    logic                  second_hit;

    ysyx_23060077_ld_align #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_ld_align (
        .rdata       (in_lsu_rdata),
        .size        (in_ld_size),
        .is_unsigned (in_ld_unsigned),
        .addr_lo     (in_addr_lo),
        .data        (ld_data)
    );

    always_comb begin
        case (in_sel)
            WB_SEL_EXU: new_result = in_exu_result;
            WB_SEL_LSU: new_result = ld_data;
            WB_SEL_CSR: new_result = in_csr_result;
            default:    new_result = in_exu_result;
        endcase
    end

    // in_ready depends only on the registered count, so a full buffer stays
    // closed for the cycle in which it drains.
    assign in_ready     = (count < 2'(WB_FIFO_DEPTH));
    assign retire_valid = (count != 2'd0);
    assign enq          = in_valid & in_ready;
    assign deq          = retire_valid & retire_ready;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= 2'd0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
        end else begin
            if (enq) begin
                mem[wr_ptr] <= '{result: new_result,
                                 rd:     in_rd,
                                 wen:    in_rd_wen & (in_rd != '0),
                                 pc:     in_pc};
                wr_ptr      <= ~wr_ptr;
            end
            if (deq) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(enq) - 2'(deq);
        end
    end

    assign head   = mem[rd_ptr];
    assign second = mem[~rd_ptr];

    assign retire_pc = head.pc;
    assign rf_waddr  = head.rd;
    assign rf_wdata  = head.result;
    // The reset cycle must not write the register file even with entries still held.
    assign rf_wen    = rst_n & deq & head.wen;

    // The second slot is the younger entry whenever both are occupied.
    assign head_hit   = (count != 2'd0) & head.wen & (head.rd == lk_rs) & (lk_rs != '0);
    assign second_hit = (count == 2'd2) & second.wen & (second.rd == lk_rs) & (lk_rs != '0);
    assign lk_hit     = head_hit | second_hit;

    always_comb begin
        lk_data = '0;
        if (second_hit)    lk_data = second.result;
        else if (head_hit) lk_data = head.result;
    end

endmodule
